// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch (IFU) and load/store (LSU) requesters.
// Round-robin arbitration, one outstanding transaction, watchdog abort on a hung memory.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // A zero timeout disables the watchdog; keep the counter at least one bit wide then.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic           WDOG_EN  = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    logic             last_owner_r;
    logic [CNT_W-1:0] cnt_r;

    logic [1:0]       grant_s;
    logic             expire_s;
    logic             finish_s;
    logic             abort_s;
    logic [31:0]      fin_data_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Returns {grant_lsu, grant_ifu}; on a tie the requester that did not win last time goes.
    function automatic logic [1:0] pick_winner(input logic ifu_v, input logic lsu_v,
                                               input logic last_owner);
        logic [1:0] g;
        if (ifu_v && lsu_v) begin
            if (last_owner == OWNER_IFU) begin
                g = 2'b10;
            end else begin
                g = 2'b01;
            end
        end else if (lsu_v) begin
            g = 2'b10;
        end else if (ifu_v) begin
            g = 2'b01;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    // Grant is only offered in IDLE and never while reset is held.
    always_comb begin
        grant_s = 2'b00;
        if ((state_r == ST_IDLE) && reset) begin
            grant_s = pick_winner(ifu_req_valid, lsu_req_valid, last_owner_r);
        end else begin
            grant_s = 2'b00;
        end
    end

    assign ifu_req_ready = grant_s[0];
    assign lsu_req_ready = grant_s[1];

    // Watchdog: the cycle in which the counter reaches its last value is the abort cycle.
    always_comb begin
        expire_s   = 1'b0;
        cnt_next_s = cnt_r;
        if (WDOG_EN && ((state_r == ST_REQ) || (state_r == ST_WAIT))) begin
            expire_s = (cnt_r == CNT_LAST);
        end else begin
            expire_s = 1'b0;
        end
        if (WDOG_EN && (cnt_r != CNT_LAST)) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // End of transaction: a real response beats a coincident timeout.
    always_comb begin
        finish_s   = 1'b0;
        abort_s    = 1'b0;
        fin_data_s = 32'h0000_0000;
        if ((state_r == ST_WAIT) && mem_resp_valid) begin
            finish_s   = 1'b1;
            abort_s    = 1'b0;
            fin_data_s = mem_wen ? 32'h0000_0000 : mem_rdata;
        end else if (expire_s) begin
            finish_s   = 1'b1;
            abort_s    = 1'b1;
            fin_data_s = ERR_DATA;
        end else begin
            finish_s   = 1'b0;
            abort_s    = 1'b0;
            fin_data_s = 32'h0000_0000;
        end
    end

    // Transaction FSM, registered request payload, response delivery and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            last_owner_r   <= OWNER_IFU;
            cnt_r          <= '0;
            mem_req_valid  <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= 32'h0000_0000;
            mem_wdata      <= 32'h0000_0000;
            mem_wmask      <= 8'h00;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= 32'h0000_0000;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= 32'h0000_0000;
            bus_err        <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        last_owner_r <= grant_s[1];
                        if (grant_s[1]) begin
                            mem_wen   <= lsu_wen;
                            mem_addr  <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            mem_wen   <= 1'b0;
                            mem_addr  <= ifu_addr;
                            mem_wdata <= 32'h0000_0000;
                            mem_wmask <= 8'h0F;
                        end
                        mem_req_valid <= 1'b1;
                        cnt_r         <= '0;
                        state_r       <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (finish_s) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= ST_RESP;
                        if (last_owner_r == OWNER_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= fin_data_s;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= fin_data_s;
                        end
                        if (abort_s) begin
                            bus_err <= 1'b1;
                        end else begin
                            bus_err <= bus_err;
                        end
                    end else if ((state_r == ST_REQ) && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt_r         <= cnt_next_s;
                        state_r       <= ST_WAIT;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
